gain_sched: RTL and testbench

GAIN_SCHED -- requirements
Module: gain_sched

---
 rtl/gain_sched.sv | 148 ++++++++++++++
 tb/tb_gain_sched.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/gain_sched.sv
// Round-robin scheduled per-channel gain multiplier: grants one requester,
// multiplies its sample by that channel's gain register and holds the result.
module gain_sched #(
   parameter int unsigned N    = 32,
   parameter int unsigned NREQ = 4,
   parameter int unsigned SAT  = 0
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [NREQ-1:0]   req_valid_i,
   input  logic [NREQ*N-1:0] req_data_i,
   output logic [NREQ-1:0]   req_ready_o,
   input  logic              cfg_we_i,
   input  logic [2:0]        cfg_ch_i,
   input  logic [N-1:0]      cfg_gain_i,
   output logic              res_valid_o,
   input  logic              res_ready_i,
   output logic [2:0]        res_ch_o,
   output logic [N-1:0]      res_data_o,
   output logic              res_ovf_o,
   output logic              busy_o
);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_HOLD} state_t;

   state_t           r_state;
   state_t           w_next;
   logic [N-1:0]     r_gain [NREQ];
   logic [2:0]       r_prio;
   logic             r_recover;
   logic [N-1:0]     r_op_a;
   logic [N-1:0]     r_op_b;
   logic [2:0]       r_op_ch;
   logic             r_res_valid;
   logic [2:0]       r_res_ch;
   logic [N-1:0]     r_res_data;
   logic             r_res_ovf;

   logic [2*NREQ-1:0] w_req2;
   logic              w_grant;
   logic [2:0]        w_gnt_ch;
   logic [NREQ-1:0]   w_gnt_vec;
   logic [N-1:0]      w_sel_data;
   logic [N-1:0]      w_sel_gain;
   logic [2:0]        w_next_prio;
   logic [2*N-1:0]    w_prod;
   logic              w_ovf;

   assign w_req2 = {req_valid_i, req_valid_i};

   // Scan the doubled request vector starting at the priority pointer so the
   // search wraps without modular arithmetic. The first IDLE cycle after a
   // result is accepted grants nothing, giving one result per 4 clocks.
   always_comb begin
      w_grant  = 1'b0;
      w_gnt_ch = '0;
      if (r_state == S_IDLE && !r_recover && !rst_i) begin
         for (int unsigned j = 0; j < 2*NREQ; j++) begin
            if (!w_grant && j >= 32'(r_prio) && j < 32'(r_prio) + NREQ && w_req2[j]) begin
               w_grant  = 1'b1;
               w_gnt_ch = 3'((j >= NREQ) ? j - NREQ : j);
            end
         end
      end
   end

   always_comb begin
      w_gnt_vec  = '0;
      w_sel_data = '0;
      w_sel_gain = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         if (w_gnt_ch == 3'(k)) begin
            w_gnt_vec[k] = w_grant;
            w_sel_data   = req_data_i[k*N +: N];
            w_sel_gain   = r_gain[k];
         end
      end
   end

   assign w_next_prio = (w_gnt_ch == 3'(NREQ-1)) ? '0 : w_gnt_ch + 3'd1;
   assign w_prod      = (2*N)'(r_op_a) * (2*N)'(r_op_b);
   assign w_ovf       = |w_prod[2*N-1:N];

   always_ff @(posedge clk_i) begin
      if (rst_i) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_grant) w_next = S_CALC;
         S_CALC:  w_next = S_HOLD;
         S_HOLD:  if (res_ready_i) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int unsigned k = 0; k < NREQ; k++) r_gain[k] <= N'(1);
         r_prio      <= '0;
         r_recover   <= 1'b0;
         r_op_a      <= '0;
         r_op_b      <= '0;
         r_op_ch     <= '0;
         r_res_valid <= 1'b0;
         r_res_ch    <= '0;
         r_res_data  <= '0;
         r_res_ovf   <= 1'b0;
      end else begin
         for (int unsigned k = 0; k < NREQ; k++) begin
            if (cfg_we_i && cfg_ch_i == 3'(k)) r_gain[k] <= cfg_gain_i;
         end
         if (w_grant) begin
            r_op_a  <= w_sel_data;
            r_op_b  <= w_sel_gain;
            r_op_ch <= w_gnt_ch;
            r_prio  <= w_next_prio;
         end
         r_recover <= 1'b0;
         case (r_state)
            S_CALC: begin
               r_res_valid <= 1'b1;
               r_res_ch    <= r_op_ch;
               r_res_ovf   <= w_ovf;
               if (SAT != 0 && w_ovf) r_res_data <= '1;
               else                   r_res_data <= w_prod[N-1:0];
            end
            S_HOLD: begin
               if (res_ready_i) begin
                  r_res_valid <= 1'b0;
                  r_recover   <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign req_ready_o = w_gnt_vec;
   assign res_valid_o = r_res_valid;
   assign res_ch_o    = r_res_ch;
   assign res_data_o  = r_res_data;
   assign res_ovf_o   = r_res_ovf;
   assign busy_o      = (r_state != S_IDLE);

endmodule

// File: tb/tb_gain_sched.sv
// Directed bench for gain_sched (N=32, NREQ=4, SAT=0) with hand-computed results.
module tb_gain_sched;

   logic          clk = 1'b0;
   logic          rst;
   logic [3:0]    req_valid;
   logic [127:0]  req_data;
   logic [3:0]    req_ready;
   logic          cfg_we;
   logic [2:0]    cfg_ch;
   logic [31:0]   cfg_gain;
   logic          res_valid;
   logic          res_ready;
   logic [2:0]    res_ch;
   logic [31:0]   res_data;
   logic          res_ovf;
   logic          busy;

   int unsigned checks   = 0;
   int unsigned failures = 0;

   always #5 clk = ~clk;

   gain_sched #(.N(32), .NREQ(4), .SAT(0)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .req_valid_i (req_valid),
      .req_data_i  (req_data),
      .req_ready_o (req_ready),
      .cfg_we_i    (cfg_we),
      .cfg_ch_i    (cfg_ch),
      .cfg_gain_i  (cfg_gain),
      .res_valid_o (res_valid),
      .res_ready_i (res_ready),
      .res_ch_o    (res_ch),
      .res_data_o  (res_data),
      .res_ovf_o   (res_ovf),
      .busy_o      (busy)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      // reset with requests pending and a write to gain[0] that must be ignored
      rst = 1'b1; req_valid = 4'hF; req_data = '0; cfg_we = 1'b1; cfg_ch = 3'd0;
      cfg_gain = 32'd7; res_ready = 1'b0;
      #1;
      chk("rst_ready_comb", 64'(req_ready), 64'h0);
      tick();
      chk("rst_ready", 64'(req_ready), 64'h0);
      chk("rst_valid", 64'(res_valid), 64'h0);
      chk("rst_data",  64'(res_data),  64'h0);
      chk("rst_ch",    64'(res_ch),    64'h0);
      chk("rst_ovf",   64'(res_ovf),   64'h0);
      chk("rst_busy",  64'(busy),      64'h0);

      // unity path
      rst = 1'b0; cfg_we = 1'b0; req_valid = 4'b0001; req_data[31:0] = 32'h0000_1234;
      res_ready = 1'b1;
      #1;
      chk("u_grant", 64'(req_ready), 64'h1);
      tick(); req_valid = 4'b0000; #1;
      chk("u_calc_ready", 64'(req_ready), 64'h0);
      chk("u_calc_valid", 64'(res_valid), 64'h0);
      chk("u_calc_busy",  64'(busy),      64'h1);
      tick(); #1;
      chk("u_valid", 64'(res_valid), 64'h1);
      chk("u_data",  64'(res_data),  64'h1234);
      chk("u_ch",    64'(res_ch),    64'h0);
      chk("u_ovf",   64'(res_ovf),   64'h0);
      tick(); #1;
      chk("u_done_valid", 64'(res_valid), 64'h0);
      chk("u_done_busy",  64'(busy),      64'h0);

      // reset pulse, then round-robin with all channels continuously valid
      rst = 1'b1;
      tick();
      rst = 1'b0; req_valid = 4'hF;
      for (int k = 0; k < 4; k++) req_data[k*32 +: 32] = 32'(k + 1);
      for (int c = 0; c < 20; c++) begin
         #1;
         chk("rr_ready", 64'(req_ready), (c % 4 == 0) ? 64'(1 << ((c / 4) % 4)) : 64'h0);
         if (c % 4 == 2) begin
            chk("rr_valid", 64'(res_valid), 64'h1);
            chk("rr_ch",    64'(res_ch),    64'((c / 4) % 4));
            chk("rr_data",  64'(res_data),  64'(((c / 4) % 4) + 1));
         end
         tick();
      end

      // overflow plus 10 clocks of backpressure; pointer now favours ch1
      req_valid = 4'b0000; cfg_we = 1'b1; cfg_ch = 3'd2; cfg_gain = 32'h0001_0000;
      tick();
      cfg_we = 1'b0; req_valid = 4'b0101; req_data[95:64] = 32'h0002_0000;
      req_data[31:0] = 32'h0; res_ready = 1'b0;
      #1;
      chk("ov_grant", 64'(req_ready), 64'h4);
      tick(); req_valid = 4'b0001; cfg_we = 1'b1; cfg_ch = 3'd2; cfg_gain = 32'd5; #1;
      chk("ov_calc_ready", 64'(req_ready), 64'h0);
      chk("ov_calc_valid", 64'(res_valid), 64'h0);
      tick(); cfg_we = 1'b0; #1;
      for (int i = 0; i < 10; i++) begin
         chk("bp_valid", 64'(res_valid), 64'h1);
         chk("bp_data",  64'(res_data),  64'h0);
         chk("bp_ovf",   64'(res_ovf),   64'h1);
         chk("bp_ch",    64'(res_ch),    64'h2);
         chk("bp_ready", 64'(req_ready), 64'h0);
         chk("bp_busy",  64'(busy),      64'h1);
         tick();
      end
      res_ready = 1'b1; #1;
      chk("bp_last_valid", 64'(res_valid), 64'h1);
      tick(); #1;
      chk("bp_rel_valid", 64'(res_valid), 64'h0);
      chk("bp_rel_busy",  64'(busy),      64'h0);
      chk("bp_rel_ready", 64'(req_ready), 64'h0);
      tick(); #1;
      chk("z_grant", 64'(req_ready), 64'h1);
      tick(); req_valid = 4'b0000;
      tick(); #1;
      chk("z_data", 64'(res_data), 64'h0);
      chk("z_ovf",  64'(res_ovf),  64'h0);
      chk("z_ch",   64'(res_ch),   64'h0);

      // gain write colliding with a ch1 grant; out-of-range write ignored
      tick(); cfg_we = 1'b1; cfg_ch = 3'd1; cfg_gain = 32'd2;
      tick(); cfg_gain = 32'd3; req_valid = 4'b0010; req_data[63:32] = 32'd5; #1;
      chk("col_grant", 64'(req_ready), 64'h2);
      tick(); req_valid = 4'b0000; cfg_ch = 3'd5; cfg_gain = 32'd0;
      tick(); cfg_we = 1'b0; #1;
      chk("col_data_old", 64'(res_data), 64'd10);
      chk("col_ch",       64'(res_ch),   64'h1);
      tick();
      tick(); req_valid = 4'b0010; #1;
      chk("col2_grant", 64'(req_ready), 64'h2);
      tick(); req_valid = 4'b0000;
      tick(); #1;
      chk("col2_data_new", 64'(res_data), 64'd15);

      // gain 0 on a full-scale sample
      tick(); cfg_we = 1'b1; cfg_ch = 3'd3; cfg_gain = 32'd0;
      tick(); cfg_we = 1'b0; req_valid = 4'b1000; req_data[127:96] = 32'hFFFF_FFFF; #1;
      chk("g0_grant", 64'(req_ready), 64'h8);
      tick(); req_valid = 4'b0000;
      tick(); #1;
      chk("g0_data", 64'(res_data), 64'h0);
      chk("g0_ovf",  64'(res_ovf),  64'h0);
      chk("g0_ch",   64'(res_ch),   64'h3);

      // reset during CALC abandons the operation and restores pointer and gains
      tick();
      tick(); req_valid = 4'b0100; req_data[95:64] = 32'd7; #1;
      chk("mr_grant", 64'(req_ready), 64'h4);
      tick(); req_valid = 4'b0000; rst = 1'b1; #1;
      chk("mr_ready", 64'(req_ready), 64'h0);
      tick(); rst = 1'b0; #1;
      chk("mr_valid0", 64'(res_valid), 64'h0);
      chk("mr_busy",   64'(busy),      64'h0);
      tick(); #1;
      chk("mr_valid1", 64'(res_valid), 64'h0);
      tick(); #1;
      chk("mr_valid2", 64'(res_valid), 64'h0);
      req_valid = 4'hF; req_data[31:0] = 32'd9; req_data[63:32] = 32'd5; #1;
      chk("mr_grant0", 64'(req_ready), 64'h1);
      tick(); req_valid = 4'b1110;
      tick(); #1;
      chk("mr_data0", 64'(res_data), 64'd9);
      chk("mr_ch0",   64'(res_ch),   64'h0);
      tick();
      tick(); #1;
      chk("mr_grant1", 64'(req_ready), 64'h2);
      tick(); req_valid = 4'b0000;
      tick(); #1;
      chk("mr_data1", 64'(res_data), 64'd5);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
